// File: rtl/region_bin_auto_proc_pkg.sv
// Shared constants, state type and arithmetic helper for the 5x5 local-mean binarizer.
package region_bin_auto_proc_pkg;

  localparam int WIN         = 5;   // window edge length
  localparam int LAT         = 5;   // input row r+2 start -> output row r start
  localparam int PIPE_STAGES = 3;   // tap, window, compare
  localparam int FLUSH_IDLE  = 10;  // idle output cycles before each flush line

  // Down-counter load after the last column step of a line, so that the flush
  // line's first output lands exactly FLUSH_IDLE idle cycles after the previous burst.
  localparam int FLUSH_LOAD  = PIPE_STAGES + FLUSH_IDLE - LAT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH_WAIT
  } step_state_e;

  function automatic logic [12:0] times25(input logic [7:0] v);
    return {1'b0, v, 4'b0000} + {2'b00, v, 3'b000} + {5'b00000, v};
  endfunction

endpackage

// File: rtl/region_bin_line_buffer.sv
// Four chained line delays giving five vertically aligned taps (tap 0 = newest row).
// Taps are valid the cycle after in_en; RAM contents are never cleared.
module region_bin_line_buffer
  import region_bin_auto_proc_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int AW        = $clog2(IMG_HDISP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_en,
  input  logic [AW-1:0]      in_addr,
  input  logic [7:0]         in_pix,
  output logic [8*WIN-1:0]   taps
);

  localparam int LINES = WIN - 1;

  logic [7:0]             mem [LINES][IMG_HDISP];
  logic [LINES-1:0][7:0]  rd_q, rd_d;
  logic [7:0]             pix_q, pix_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   en_q, en_d;

  always_comb begin
    en_d   = in_en;
    addr_d = in_addr;
    pix_d  = in_pix;
    rd_d   = rd_q;
    for (int i = 0; i < LINES; i++) begin
      rd_d[i] = mem[i][in_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      pix_q  <= '0;
      rd_q   <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      pix_q  <= pix_d;
      rd_q   <= rd_d;
    end
  end

  // Write back one cycle after the read: each line moves one RAM deeper.
  always_ff @(posedge clk) begin
    if (en_q) begin
      mem[0][addr_q] <= pix_q;
      for (int i = 1; i < LINES; i++) begin
        mem[i][addr_q] <= rd_q[i-1];
      end
    end
  end

  always_comb begin
    taps      = '0;
    taps[7:0] = pix_q;
    for (int i = 1; i < WIN; i++) begin
      taps[8*i +: 8] = rd_q[i-1];
    end
  end

endmodule

// File: rtl/region_bin_auto_proc.sv
// 5x5 zero-padded local-mean binarizer: pixel -> FF when 25*centre >= window sum.
// state         | meaning
// ST_IDLE       | waiting for an input href burst (or frame not active)
// ST_RUN        | stepping columns 1..IMG_HDISP+1 of the current line
// ST_FLUSH_WAIT | gap timer running before a self-generated zero-fed line
module region_bin_auto_proc
  import region_bin_auto_proc_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_gray
);

  localparam int CW = $clog2(IMG_HDISP + 2);
  localparam int RW = $clog2(IMG_VDISP + WIN);
  localparam int AW = $clog2(IMG_HDISP);

  localparam logic [CW-1:0] COL_H    = CW'(IMG_HDISP);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_HDISP + 1);
  localparam logic [RW-1:0] ROW_V    = RW'(IMG_VDISP);
  localparam logic [RW-1:0] ROW_LIN  = RW'(IMG_VDISP - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_VDISP + 1);

  step_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, col;
  logic [RW-1:0] row_q, row_d;
  logic [3:0]    gap_q, gap_d;
  logic          frame_q, frame_d;
  logic          vs_prev_q, vs_prev_d;
  logic          step, vs_rise;

  logic               lb_en;
  logic [7:0]         lb_pix;
  logic [8*WIN-1:0]   taps;

  logic               t_vld_q, t_vld_d, t_last_q, t_last_d, t_colv_q, t_colv_d;
  logic [WIN-1:0]     t_rmask_q, t_rmask_d;
  logic [WIN-1:0][10:0] cs_q, cs_d;
  logic [2:0][7:0]    ctr_q, ctr_d;
  logic               w_vld_q, w_vld_d, w_last_q, w_last_d;
  logic [10:0]        col_sum;
  logic [7:0]         centre;
  logic [12:0]        s_sum, t_val;
  logic               href_q, href_d, o_last_q, o_last_d, vsync_q, vsync_d;
  logic [7:0]         gray_q, gray_d;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_d     = gap_q;
    frame_d   = frame_q;
    vs_prev_d = per_img_vsync;
    vs_rise   = per_img_vsync && !vs_prev_q;
    step      = 1'b0;
    col       = col_q;
    case (state_q)
      ST_IDLE: begin
        col  = '0;
        step = frame_q && (row_q < ROW_V) && per_img_href;
      end
      ST_RUN: step = 1'b1;
      ST_FLUSH_WAIT: begin
        col = '0;
        if (gap_q == 4'd0) step = 1'b1;
        else               gap_d = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (step) begin
      if (col == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
        if (row_q == ROW_LAST) begin
          state_d = ST_IDLE;
          frame_d = 1'b0;
          row_d   = '0;
        end else if (row_q >= ROW_LIN) begin
          state_d = ST_FLUSH_WAIT;
          gap_d   = 4'(FLUSH_LOAD);
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        col_d   = col + CW'(1);
        state_d = ST_RUN;
      end
    end
    // A new frame always wins, aborting any flush still in progress.
    if (vs_rise) begin
      state_d = ST_IDLE;
      col_d   = '0;
      row_d   = '0;
      gap_d   = '0;
      frame_d = 1'b1;
    end
  end

  // Tap stage: pixel/address to the line buffer plus row/column validity masks.
  always_comb begin
    lb_en     = step && (col < COL_H);
    lb_pix    = (row_q < ROW_V) ? per_img_gray : 8'h00;
    t_vld_d   = step && (col >= CW'(2)) && (row_q >= RW'(2)) && !vs_rise;
    t_last_d  = step && (col == COL_LAST) && (row_q == ROW_LAST) && !vs_rise;
    t_colv_d  = step && (col < COL_H);
    t_rmask_d = '0;
    for (int i = 0; i < WIN; i++) begin
      t_rmask_d[i] = (row_q >= RW'(i)) && (row_q < RW'(IMG_VDISP + i));
    end
  end

  region_bin_line_buffer #(
    .IMG_HDISP (IMG_HDISP),
    .AW        (AW)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_en   (lb_en),
    .in_addr (col[AW-1:0]),
    .in_pix  (lb_pix),
    .taps    (taps)
  );

  // Window stage: keep five masked column sums and the centre-row pixels.
  always_comb begin
    col_sum = '0;
    for (int i = 0; i < WIN; i++) begin
      if (t_colv_q && t_rmask_q[i]) col_sum = col_sum + 11'(taps[8*i +: 8]);
    end
    centre   = (t_colv_q && t_rmask_q[2]) ? taps[23:16] : 8'h00;
    cs_d     = {cs_q[WIN-2:0], col_sum};
    ctr_d    = {ctr_q[1:0], centre};
    w_vld_d  = t_vld_q && !vs_rise;
    w_last_d = t_last_q && !vs_rise;
  end

  always_comb begin
    s_sum = '0;
    for (int j = 0; j < WIN; j++) begin
      s_sum = s_sum + 13'(cs_q[j]);
    end
    t_val    = times25(ctr_q[2]);
    href_d   = w_vld_q && !vs_rise;
    gray_d   = (w_vld_q && !vs_rise && (t_val >= s_sum)) ? 8'hFF : 8'h00;
    o_last_d = w_last_q && !vs_rise;
    vsync_d  = vsync_q;
    if (o_last_q) vsync_d = 1'b0;
    if (vs_rise)  vsync_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      gap_q     <= '0;
      frame_q   <= 1'b0;
      vs_prev_q <= 1'b1;  // a frame already in progress at reset release is ignored
      t_vld_q   <= 1'b0;
      t_last_q  <= 1'b0;
      t_colv_q  <= 1'b0;
      t_rmask_q <= '0;
      cs_q      <= '0;
      ctr_q     <= '0;
      w_vld_q   <= 1'b0;
      w_last_q  <= 1'b0;
      href_q    <= 1'b0;
      gray_q    <= 8'h00;
      o_last_q  <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      gap_q     <= gap_d;
      frame_q   <= frame_d;
      vs_prev_q <= vs_prev_d;
      t_vld_q   <= t_vld_d;
      t_last_q  <= t_last_d;
      t_colv_q  <= t_colv_d;
      t_rmask_q <= t_rmask_d;
      cs_q      <= cs_d;
      ctr_q     <= ctr_d;
      w_vld_q   <= w_vld_d;
      w_last_q  <= w_last_d;
      href_q    <= href_d;
      gray_q    <= gray_d;
      o_last_q  <= o_last_d;
      vsync_q   <= vsync_d;
    end
  end

  assign post_img_vsync = vsync_q;
  assign post_img_href  = href_q;
  assign post_img_gray  = gray_q;

endmodule

// File: tb/tb_region_bin_auto_proc.sv
// Directed + random frames for region_bin_auto_proc, checked against a direct 5x5 mean model.
module tb_region_bin_auto_proc;

  localparam int H  = 32;
  localparam int V  = 16;
  localparam int MR = V + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_img_vsync = 1'b0;
  logic       per_img_href = 1'b0;
  logic [7:0] per_img_gray = 8'h00;
  logic       post_img_vsync;
  logic       post_img_href;
  logic [7:0] post_img_gray;

  always #5 clk = ~clk;

  region_bin_auto_proc #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_gray   (per_img_gray),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_gray  (post_img_gray)
  );

  int img     [V][H];
  int out_img [MR][H];
  int ostart [MR];
  int oend   [MR];
  int olen   [MR];
  int istart [MR];
  int nb = 0, ni = 0, cyc = 0, vs_fall = -1, gray_bad = 0, vs_at_first = -1, ocol = 0;
  logic ohref_p = 1'b0, ihref_p = 1'b0, ovs_p = 1'b0;
  int vecs = 0, errs = 0;

  // Output/input activity recorder, sampled on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (post_img_href === 1'b1) begin
        if (!ohref_p) begin
          if (nb < MR) ostart[nb] = cyc;
          if (nb == 0) vs_at_first = (post_img_vsync === 1'b1) ? 1 : 0;
          ocol = 0;
        end
        if (nb < MR && ocol < H) out_img[nb][ocol] = int'(post_img_gray);
        ocol++;
      end else begin
        if (ohref_p) begin
          if (nb < MR) begin
            olen[nb] = ocol;
            oend[nb] = cyc - 1;
          end
          nb++;
        end
        if (post_img_gray !== 8'h00) gray_bad++;
      end
      if (ovs_p && post_img_vsync === 1'b0) vs_fall = cyc;
      if (per_img_href && !ihref_p) begin
        if (ni < MR) istart[ni] = cyc;
        ni++;
      end
      ohref_p = (post_img_href === 1'b1);
      ihref_p = per_img_href;
      ovs_p   = (post_img_vsync === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gold(input int r, input int c);
    int s;
    s = 0;
    for (int dr = -2; dr <= 2; dr++) begin
      for (int dc = -2; dc <= 2; dc++) begin
        if (r + dr >= 0 && r + dr < V && c + dc >= 0 && c + dc < H) s += img[r+dr][c+dc];
      end
    end
    return (25 * img[r][c] >= s) ? 255 : 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    nb = 0; ni = 0; vs_fall = -1; gray_bad = 0; vs_at_first = -1;
  endtask

  task automatic drive_row(input int r);
    per_img_href = 1'b1;
    for (int c = 0; c < H; c++) begin
      per_img_gray = 8'(img[r][c]);
      tick(1);
    end
    per_img_href = 1'b0;
    per_img_gray = 8'h00;
    tick(12);
  endtask

  task automatic check_frame(input string tag);
    int bad;
    chk({tag, " bursts"}, nb, V);
    chk({tag, " vsync_with_first_href"}, vs_at_first, 1);
    chk({tag, " gray_between_bursts"}, gray_bad, 0);
    for (int r = 0; r < V; r++) begin
      chk($sformatf("%s len_r%0d", tag, r), olen[r], H);
      bad = 0;
      for (int c = 0; c < H; c++) if (out_img[r][c] !== gold(r, c)) bad++;
      chk($sformatf("%s bad_pixels_r%0d", tag, r), bad, 0);
    end
    for (int r = 0; r <= V - 3; r++)
      chk($sformatf("%s latency_r%0d", tag, r), ostart[r] - istart[r+2], 5);
    chk({tag, " flush1_gap"}, ostart[V-2] - oend[V-3], 11);
    chk({tag, " flush2_gap"}, ostart[V-1] - oend[V-2], 11);
    chk({tag, " vsync_fall"}, vs_fall - oend[V-1], 1);
  endtask

  task automatic run_frame(input string tag);
    clear_mon();
    per_img_vsync = 1'b1;
    tick(12);
    for (int r = 0; r < V; r++) drive_row(r);
    for (int i = 0; i < 400 && vs_fall < 0; i++) tick(1);
    chk({tag, " frame_end_seen"}, (vs_fall >= 0) ? 1 : 0, 1);
    per_img_vsync = 1'b0;
    tick(4);
    check_frame(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    tick(3);
    chk("reset vsync", post_img_vsync, 0);
    chk("reset href", post_img_href, 0);
    chk("reset gray", post_img_gray, 0);
    rst_n = 1'b1;
    tick(5);

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = 128;
    run_frame("flat80");
    chk("flat80 corner", out_img[0][0], 255);

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = 0;
    run_frame("flat00");

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = 50;
    img[10][10] = 200;
    run_frame("spot");
    chk("spot centre", out_img[10][10], 255);
    chk("spot 8_8", out_img[8][8], 0);
    chk("spot 12_12", out_img[12][12], 0);
    chk("spot 10_12", out_img[10][12], 0);
    chk("spot far", out_img[3][25], 255);

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = (c < H/2) ? 20 : 220;
    run_frame("stripes");
    // Dark side of the edge falls below its local mean, bright side stays above.
    chk("stripes c14", out_img[7][H/2-2], 0);
    chk("stripes c15", out_img[7][H/2-1], 0);
    chk("stripes c16", out_img[7][H/2], 255);
    chk("stripes c17", out_img[7][H/2+1], 255);

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame("rand1");

    // Reset in the middle of row 6; the rest of that frame must produce nothing.
    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = int'($urandom_range(0, 255));
    clear_mon();
    per_img_vsync = 1'b1;
    tick(12);
    for (int r = 0; r < 6; r++) drive_row(r);
    per_img_href = 1'b1;
    for (int c = 0; c < H/2; c++) begin
      per_img_gray = 8'(img[6][c]);
      tick(1);
    end
    rst_n = 1'b0;
    per_img_href = 1'b0;
    per_img_gray = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("midreset vsync c%0d", i), post_img_vsync, 0);
      chk($sformatf("midreset href c%0d", i), post_img_href, 0);
      chk($sformatf("midreset gray c%0d", i), post_img_gray, 0);
    end
    rst_n = 1'b1;
    tick(12);
    clear_mon();
    for (int r = 7; r < V; r++) drive_row(r);
    tick(150);
    chk("discarded frame bursts", nb, 0);
    chk("discarded frame vsync", post_img_vsync, 0);
    per_img_vsync = 1'b0;
    tick(5);

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = int'($urandom_range(0, 255));
    run_frame("after_reset");

    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) img[r][c] = int'($urandom_range(0, 3)) * 85;
    run_frame("rand_levels");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
